// File: rtl/wb_copy_dma_if.sv
// Wishbone classic bus bundle shared by the copy engine and the peripherals it drives.
interface wb_copy_dma_if;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;

    modport master (
        output addr, data_wr, sel, we, cyc, stb,
        input  data_rd, ack, err
    );

    modport slave (
        input  addr, data_wr, sel, we, cyc, stb,
        output data_rd, ack, err
    );
endinterface

// File: rtl/wb_copy_dma.sv
// Wishbone classic initiator copying a block of 32-bit words, one read then one write per word,
// with a per-transaction watchdog and sticky error reporting.
module wb_copy_dma #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    wb_copy_dma_if.master        wb,
    input  logic                 i_start,
    input  logic [31:0]          i_src_addr,
    input  logic [31:0]          i_dst_addr,
    input  logic [LEN_WIDTH-1:0] i_len_words,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [31:0]          o_err_addr,
    output logic [LEN_WIDTH-1:0] o_words_done
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_GAP,
        WR,
        WR_GAP,
        DONE
    } state_t;

    // The watchdog only has to count up to TIMEOUT_CYCLES-1 before it fires.
    localparam int WD_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_WIDTH-1:0] WD_LAST =
        WD_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    state_t                state;
    logic [31:0]           src_ptr;
    logic [31:0]           dst_ptr;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [31:0]           data_buf;
    logic [WD_WIDTH-1:0]   watchdog;
    logic                  wd_expired;

    assign wd_expired = (TIMEOUT_CYCLES != 0) && (watchdog == WD_LAST);

    // o_words_done doubles as the word index; the pointers advance by one word per completed write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            wb.cyc       <= 1'b0;
            wb.stb       <= 1'b0;
            wb.we        <= 1'b0;
            wb.sel       <= 4'h0;
            wb.addr      <= 32'h0;
            wb.data_wr   <= 32'h0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_err_addr   <= 32'h0;
            o_words_done <= '0;
            src_ptr      <= 32'h0;
            dst_ptr      <= 32'h0;
            len_q        <= '0;
            data_buf     <= 32'h0;
            watchdog     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_busy       <= 1'b1;
                        o_error      <= 1'b0;
                        o_words_done <= '0;
                        src_ptr      <= i_src_addr;
                        dst_ptr      <= i_dst_addr;
                        len_q        <= i_len_words;
                        if (i_src_addr[1:0] != 2'b00) begin
                            o_error    <= 1'b1;
                            o_err_addr <= i_src_addr;
                            o_done     <= 1'b1;
                            state      <= DONE;
                        end else if (i_dst_addr[1:0] != 2'b00) begin
                            o_error    <= 1'b1;
                            o_err_addr <= i_dst_addr;
                            o_done     <= 1'b1;
                            state      <= DONE;
                        end else if (i_len_words == '0) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            wb.cyc   <= 1'b1;
                            wb.stb   <= 1'b1;
                            wb.we    <= 1'b0;
                            wb.sel   <= 4'hF;
                            wb.addr  <= i_src_addr;
                            watchdog <= '0;
                            state    <= RD;
                        end
                    end
                end

                RD, WR: begin
                    // err wins over a simultaneous ack; a late ack still beats a watchdog expiring that cycle.
                    if (wb.err || (!wb.ack && wd_expired)) begin
                        wb.cyc     <= 1'b0;
                        wb.stb     <= 1'b0;
                        o_error    <= 1'b1;
                        o_err_addr <= wb.addr;
                        o_done     <= 1'b1;
                        state      <= DONE;
                    end else if (wb.ack) begin
                        wb.cyc <= 1'b0;
                        wb.stb <= 1'b0;
                        if (state == RD) begin
                            data_buf <= wb.data_rd;
                            state    <= RD_GAP;
                        end else begin
                            o_words_done <= o_words_done + 1'b1;
                            src_ptr      <= src_ptr + 32'd4;
                            dst_ptr      <= dst_ptr + 32'd4;
                            state        <= WR_GAP;
                        end
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end

                RD_GAP: begin
                    wb.cyc     <= 1'b1;
                    wb.stb     <= 1'b1;
                    wb.we      <= 1'b1;
                    wb.sel     <= 4'hF;
                    wb.addr    <= dst_ptr;
                    wb.data_wr <= data_buf;
                    watchdog   <= '0;
                    state      <= WR;
                end

                WR_GAP: begin
                    if (o_words_done == len_q) begin
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        wb.cyc   <= 1'b1;
                        wb.stb   <= 1'b1;
                        wb.we    <= 1'b0;
                        wb.sel   <= 4'hF;
                        wb.addr  <= src_ptr;
                        watchdog <= '0;
                        state    <= RD;
                    end
                end

                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    wb.we  <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
